throttle_pwm_gen: RTL

Consumer end of the altitude PID interface. Accepts the valid-qualified 15-bit PID effort word produced by the altitude controller and converts it into a glitch-free ESC servo-style PWM pulse (1000–2000 us) at a fixed frame rate. Includes arming control and a loss-of-update watchdog that forces minimum throttle. Sits between pid_altitude and the motor ESC pins of the Basic-Drone design.

---
 rtl/drone_pwm_pkg.sv | 18 +
 rtl/throttle_pwm_gen_if.sv | 8 +
 rtl/pwm_frame_timer.sv | 24 ++
 rtl/throttle_pwm_gen.sv | 56 +++++
 4 files changed

// File: rtl/drone_pwm_pkg.sv
// drone_pwm_pkg: shared constants and effort-to-pulse clamp for the ESC PWM path
package drone_pwm_pkg;
  localparam int CLK_HZ = 100_000_000;
  localparam int PULSE_W = 12;
  localparam int PID_W = 15;
  localparam int PRESCALE = CLK_HZ / 1_000_000;
  localparam int PERIOD_US = 2500;
  localparam int MIN_US = 1000;
  localparam int SPAN_US = 1000;
  localparam int PID_SHIFT = 5;
  localparam int TIMEOUT_PERIODS = 4;
  typedef logic [PULSE_W-1:0] pulse_t;
  function automatic pulse_t clamp_pulse(input logic [PID_W-1:0] pid, input int shift, input int min_us, input int span_us);
    int s;
    s = int'(pid >> shift);
    return pulse_t'(min_us + (s > span_us ? span_us : s));
  endfunction
endpackage

// File: rtl/throttle_pwm_gen_if.sv
// throttle_pwm_gen_if: valid-qualified PID effort word from the altitude controller
interface throttle_pwm_gen_if;
  import drone_pwm_pkg::*;
  logic sink_data_valid;
  logic [PID_W-1:0] sink_pid;
  modport master (output sink_data_valid, sink_pid);
  modport slave (input sink_data_valid, sink_pid);
endinterface

// File: rtl/pwm_frame_timer.sv
// pwm_frame_timer: 1 us prescaler and position-in-frame counter
module pwm_frame_timer import drone_pwm_pkg::*; #(
  parameter int PRESCALE = drone_pwm_pkg::PRESCALE,
  parameter int PERIOD_US = drone_pwm_pkg::PERIOD_US
) (
  input logic clk,
  input logic reset,
  output logic us_tick,
  output pulse_t per_cnt,
  output logic boundary
);
  localparam int UW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [UW-1:0] us_cnt;
  assign us_tick = us_cnt == UW'(PRESCALE - 1);
  assign boundary = us_tick && per_cnt == pulse_t'(PERIOD_US - 1);
  always_ff @(posedge clk)
    if (!reset) begin
      us_cnt <= '0;
      per_cnt <= '0;
    end else begin
      us_cnt <= us_tick ? '0 : us_cnt + 1'b1;
      if (us_tick) per_cnt <= boundary ? '0 : per_cnt + 1'b1;
    end
endmodule

// File: rtl/throttle_pwm_gen.sv
// throttle_pwm_gen: PID effort to ESC PWM with arming and loss-of-update failsafe
module throttle_pwm_gen import drone_pwm_pkg::*; #(
  parameter int PRESCALE = drone_pwm_pkg::PRESCALE,
  parameter int PERIOD_US = drone_pwm_pkg::PERIOD_US,
  parameter int MIN_US = drone_pwm_pkg::MIN_US,
  parameter int SPAN_US = drone_pwm_pkg::SPAN_US,
  parameter int PID_SHIFT = drone_pwm_pkg::PID_SHIFT,
  parameter int TIMEOUT_PERIODS = drone_pwm_pkg::TIMEOUT_PERIODS
) (
  input logic clk,
  input logic reset,
  throttle_pwm_gen_if.slave sink,
  input logic arm,
  output logic pwm_out,
  output pulse_t source_pulse_us,
  output logic source_period_start,
  output logic failsafe
);
  localparam int WW = $clog2(TIMEOUT_PERIODS + 1);
  localparam pulse_t MIN = pulse_t'(MIN_US);
  logic us_tick, boundary, pos_moved, failsafe_next;
  pulse_t per_cnt, pend, active, frame_pulse;
  logic [WW-1:0] wdog, wdog_next;
  pwm_frame_timer #(.PRESCALE(PRESCALE), .PERIOD_US(PERIOD_US)) u_timer (
    .clk(clk),
    .reset(reset),
    .us_tick(us_tick),
    .per_cnt(per_cnt),
    .boundary(boundary)
  );
  assign source_pulse_us = active;
  always_comb begin
    wdog_next = sink.sink_data_valid ? '0 : (boundary && wdog != WW'(TIMEOUT_PERIODS)) ? wdog + 1'b1 : wdog;
    failsafe_next = !sink.sink_data_valid && (failsafe || wdog_next == WW'(TIMEOUT_PERIODS));
    frame_pulse = (failsafe_next || !arm) ? MIN : pend;
  end
  // pwm_out can only change right after per_cnt or active moves, so it is refreshed only then
  always_ff @(posedge clk)
    if (!reset) begin
      pend <= MIN;
      active <= MIN;
      pwm_out <= 1'b0;
      source_period_start <= 1'b0;
      failsafe <= 1'b1;
      wdog <= '0;
      pos_moved <= 1'b1;
    end else begin
      wdog <= wdog_next;
      failsafe <= failsafe_next;
      source_period_start <= boundary;
      pos_moved <= us_tick;
      if (sink.sink_data_valid) pend <= clamp_pulse(sink.sink_pid, PID_SHIFT, MIN_US, SPAN_US);
      if (boundary) active <= frame_pulse;
      if (pos_moved) pwm_out <= per_cnt < active;
    end
endmodule
